stream_arbiter: RTL and testbench

- Round-robin arbiter sharing one downstream stb/ack word sink, such as a result file writer or an FPU operand port, between NUM_IN upstream producers.
- Accepts one word from the granted producer, holds it, presents it downstream, then re-arbitrates.
- Sits between multiple test/datapath sources and a single 64-bit stream consumer.

---
 rtl/stream_arb_pkg.sv | 23 ++
 rtl/stream_arbiter_rr_pick.sv | 35 +++
 rtl/stream_arbiter.sv | 93 +++++++++
 tb/tb_stream_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// Shared definitions for stream_arbiter: FSM state encoding and the source-index width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stream_arb_pkg;

  // Arbiter FSM states; encoding is fixed so external debug taps can decode it.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    SEND   = 2'd2
  } state_t;

  // Ceiling log2 used to size the source index (NUM_IN is always >= 2).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_arbiter_rr_pick.sv
// Rotated-priority pick: first set req bit searching ptr, ptr+1, ... wrapping to ptr-1.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is used.
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter  int NUM_IN = 4,
  localparam int SRC_W  = clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SRC_W-1:0]  ptr,
  output logic              any,
  output logic [SRC_W-1:0]  idx
);

  // Walk the request vector starting at ptr; the first hit wins.
  always_comb begin
    int               j;
    logic [SRC_W-1:0] pos;
    any = 1'b0;
    idx = '0;
    j   = 0;
    pos = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_IN) j = j - NUM_IN;
      pos = SRC_W'(j);
      if (!any && req[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/stream_arbiter.sv
// Round-robin arbiter sharing one registered stb/ack word sink between NUM_IN producers (optional out_tag: STREAM_ARBITER_TAG_EN).
// Latency: grant one edge after a request, word on out_stb the next edge; at least 3 cycles per word.
// Backpressure: the held word waits in SEND until out_ack; requests arriving meanwhile wait for IDLE.
module stream_arbiter
  import stream_arb_pkg::*;
#(
  parameter  int NUM_IN = 4,
  parameter  int WIDTH  = 64,
  localparam int SRC_W  = clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_stb,
  output logic [NUM_IN-1:0]       in_ack,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_stb,
`ifdef STREAM_ARBITER_TAG_EN
  output logic [SRC_W-1:0]        out_tag,
`endif
  input  logic                    out_ack
);

  state_t           state;
  logic [SRC_W-1:0] grant;
  logic [SRC_W-1:0] ptr;
  logic             pick_any;
  logic [SRC_W-1:0] pick_idx;
  logic [WIDTH-1:0] in_word [NUM_IN];

  // Unpack the flat input bus so the granted word can be selected by index.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
    assign in_word[i] = in_data[i*WIDTH +: WIDTH];
  end

  rr_pick #(.NUM_IN(NUM_IN)) u_pick (
    .req (in_stb),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Arbitration FSM: grant in IDLE, capture the word in ACCEPT, hold it downstream in SEND.
  // A producer dropping stb in ACCEPT is a protocol violation; we simply keep waiting for it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= '0;
      ptr      <= '0;
      in_ack   <= '0;
      out_stb  <= 1'b0;
      out_data <= '0;
`ifdef STREAM_ARBITER_TAG_EN
      out_tag  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant  <= pick_idx;
            in_ack <= NUM_IN'(1) << pick_idx;
            state  <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (in_stb[grant]) begin
            out_data <= in_word[grant];
`ifdef STREAM_ARBITER_TAG_EN
            out_tag  <= grant;
`endif
            in_ack   <= '0;
            out_stb  <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (out_ack) begin
            out_stb <= 1'b0;
            // Source just served drops to lowest priority for the next round.
            ptr     <= (grant == SRC_W'(NUM_IN - 1)) ? '0 : grant + 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          in_ack  <= '0;
          out_stb <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_arbiter.sv
// Self-checking bench for stream_arbiter: directed scenarios followed by randomized traffic.
// Latency: n/a.
// Backpressure: out_ack driven both directed and random.
module tb_stream_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_stb;
  logic [N-1:0]   in_ack;
  logic [W-1:0]   out_data;
  logic           out_stb;
  logic           out_ack;
`ifdef STREAM_ARBITER_TAG_EN
  logic [SW-1:0]  out_tag;
`endif

  stream_arbiter #(.NUM_IN(N), .WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_stb   (in_stb),
    .in_ack   (in_ack),
    .out_data (out_data),
    .out_stb  (out_stb),
`ifdef STREAM_ARBITER_TAG_EN
    .out_tag  (out_tag),
`endif
    .out_ack  (out_ack)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: a transfer is "pending" from grant until the downstream handshake.
  int           m_phase;
  int           m_g;
  int           m_last;
  logic [N-1:0] exp_ack;
  logic         exp_stb;
  logic [W-1:0] exp_data;
`ifdef STREAM_ARBITER_TAG_EN
  logic [SW-1:0] exp_tag;
`endif

  logic [W-1:0] words [N];
  logic [N-1:0] taken;
  int           dut_order [$];
  int           ack_cycles;
  int           stb_cycles;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Next source after the last one served that is requesting, wrapping around.
  function automatic int rr_next(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_g      = 0;
    m_last   = N - 1;
    exp_ack  = '0;
    exp_stb  = 1'b0;
    exp_data = '0;
`ifdef STREAM_ARBITER_TAG_EN
    exp_tag  = '0;
`endif
  endtask

  task automatic pack_words();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = words[i];
  endtask

  task automatic drop_taken();
    in_stb = in_stb & ~taken;
  endtask

  // One clock: advance the model on the inputs seen at the edge, then compare #1 later.
  task automatic step();
    logic [N-1:0]   s;
    logic [N-1:0]   a;
    logic [N*W-1:0] d;
    logic           oa;
    s  = in_stb;
    a  = in_ack;
    d  = in_data;
    oa = out_ack;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (s != '0) begin
        m_g     = rr_next(s, m_last);
        exp_ack = N'(1) << m_g;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (s[m_g]) begin
        exp_data = d[m_g*W +: W];
`ifdef STREAM_ARBITER_TAG_EN
        exp_tag  = SW'(m_g);
`endif
        exp_ack  = '0;
        exp_stb  = 1'b1;
        m_phase  = 2;
      end
    end else begin
      if (oa) begin
        exp_stb = 1'b0;
        m_last  = m_g;
        m_phase = 0;
      end
    end
    taken = s & a;
    #1;
    check("in_ack", W'(in_ack), W'(exp_ack));
    check("out_stb", W'(out_stb), W'(exp_stb));
    check("out_data", out_data, exp_data);
`ifdef STREAM_ARBITER_TAG_EN
    check("out_tag", W'(out_tag), W'(exp_tag));
`endif
    if (in_ack != '0) ack_cycles++;
    if (out_stb) stb_cycles++;
    if (in_ack != '0 && a == '0) begin
      for (int i = 0; i < N; i++) if (in_ack[i]) dut_order.push_back(i);
    end
  endtask

  initial begin
    int           exp_rr [6];
    int           exp_fair [4];
    logic [W-1:0] got;
`ifdef STREAM_ARBITER_TAG_EN
    logic [SW-1:0] got_tag;
    got_tag = '0;
`endif
    exp_rr   = '{0, 1, 2, 3, 0, 1};
    exp_fair = '{0, 2, 0, 2};
    got      = '0;
    model_reset();
    taken      = '0;
    ack_cycles = 0;
    stb_cycles = 0;

    // Reset held with every source requesting.
    for (int i = 0; i < N; i++) words[i] = 64'h00A0 + W'(i);
    pack_words();
    in_stb  = 4'b1111;
    out_ack = 1'b0;
    for (int c = 0; c < 3; c++) step();
    rst     = 1'b1;
    out_ack = 1'b1;

    // Continuous round robin: sources keep their words and stb high.
    step();
    check("first_grant", W'(in_ack), W'(4'b0001));
    for (int c = 0; c < 17; c++) step();
    check("rr_count", W'(dut_order.size()), W'(6));
    for (int i = 0; i < 6 && i < dut_order.size(); i++)
      check("rr_order", W'(dut_order[i]), W'(exp_rr[i]));
    check("rr_stb_cycles", W'(stb_cycles), W'(6));

    // Pulse reset to return to ptr 0.
    in_stb = '0;
    rst    = 1'b0;
    step();
    rst = 1'b1;

    // Single source 2, sink always ready.
    words[2] = 64'h0123_4567_89AB_CDEF;
    pack_words();
    in_stb     = 4'b0100;
    ack_cycles = 0;
    stb_cycles = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      drop_taken();
      if (out_stb) begin
        got = out_data;
`ifdef STREAM_ARBITER_TAG_EN
        got_tag = out_tag;
`endif
      end
    end
    check("single_ack_cycles", W'(ack_cycles), W'(1));
    check("single_stb_cycles", W'(stb_cycles), W'(1));
    check("single_word", got, 64'h0123_4567_89AB_CDEF);
`ifdef STREAM_ARBITER_TAG_EN
    check("single_tag", W'(got_tag), W'(2));
`endif

    // Backpressure on source 1; source 3 requests late and must wait.
    words[1] = 64'hDEAD_BEEF_0000_0001;
    words[3] = 64'h0000_0000_0000_00C3;
    pack_words();
    out_ack = 1'b0;
    in_stb  = 4'b0010;
    for (int c = 0; c < 5 && !out_stb; c++) begin
      step();
      drop_taken();
    end
    check("bp_reach_send", W'(out_stb), W'(1));
    in_stb[3] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check("bp_hold_data", out_data, 64'hDEAD_BEEF_0000_0001);
      check("bp_no_ack", W'(in_ack), W'(0));
    end
    out_ack = 1'b1;
    step();
    check("bp_release", W'(out_stb), W'(0));
    step();
    check("late_req_grant", W'(in_ack), W'(4'b1000));
    for (int c = 0; c < 2; c++) begin
      step();
      drop_taken();
    end

    // Serve source 2 alone so the next search starts at 3.
    in_stb = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step();
      drop_taken();
    end
    // Sources 0 and 2 requesting continuously must alternate.
    dut_order.delete();
    in_stb = 4'b0101;
    for (int c = 0; c < 12; c++) step();
    check("fair_count", W'(dut_order.size()), W'(4));
    for (int i = 0; i < 4 && i < dut_order.size(); i++)
      check("fair_order", W'(dut_order[i]), W'(exp_fair[i]));

    // Asynchronous reset while a word is held downstream.
    in_stb = '0;
    step();
    step();
    step();
    words[3] = 64'h5555_AAAA_5555_AAAA;
    pack_words();
    out_ack = 1'b0;
    in_stb  = 4'b1000;
    for (int c = 0; c < 6 && !out_stb; c++) step();
    check("arst_reach_send", W'(out_stb), W'(1));
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_stb", W'(out_stb), W'(0));
    check("arst_in_ack", W'(in_ack), W'(0));
    check("arst_out_data", out_data, W'(0));
    model_reset();
    step();
    step();
    rst     = 1'b1;
    out_ack = 1'b1;
    step();
    check("post_rst_grant", W'(in_ack), W'(4'b1000));
    step();
    drop_taken();
    check("post_rst_word", out_data, 64'h5555_AAAA_5555_AAAA);
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (taken[i]) begin
          if ($urandom_range(0, 1) == 0) in_stb[i] = 1'b0;
          else words[i] = {$urandom, $urandom};
        end else if (!in_stb[i] && $urandom_range(0, 2) == 0) begin
          words[i]  = {$urandom, $urandom};
          in_stb[i] = 1'b1;
        end
      end
      pack_words();
      out_ack = 1'($urandom_range(0, 1));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
